link_rx_align: RTL and testbench
================================

LINK_RX_ALIGN -- requirements
Module: link_rx_align

Interface
REQ-001 SHALL have parameter LOCK_COMMAS, default 3, meaning the number of consecutive same-offset commas required to lock (range 1..15).
REQ-002 SHALL have parameter ERR_LIMIT, default 4, meaning the decode errors within one error window that force loss of lock (range 1..255).
REQ-003 SHALL have parameter ERR_WINDOW, default 256, meaning the error-window length in words (power of two, 2..65536).
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 io_din  input  10  unaligned raw line word from the deserializer, one per cycle; bit 9 = line bit a (first received), bit 0 = bit j.
REQ-008 io_dec_error  input  1  error flag from the downstream decoder, which decodes io_dout combinationally in the same cycle.
REQ-009 io_dout  output  10  aligned 10-bit code group, bit order as io_din.
REQ-010 io_comma  output  1  io_dout is a comma-bearing group at the locked offset.
REQ-011 io_locked  output  1  alignment FSM is in LOCKED.
REQ-012 io_offset  output  4  current latched bit offset, 0..9.

Function
REQ-013 SHALL register io_din each cycle into prev and form window W = {prev, io_din}, 20 bits, W[19] = oldest bit.
REQ-014 For offset k in 0..9, the candidate word SHALL be W[19-k : 10-k].
REQ-015 A comma at k SHALL mean W[19-k : 13-k] equals 7'b0011111 or 7'b1100000.
REQ-016 If commas match at several offsets in one cycle, the lowest k SHALL be taken.
REQ-017 io_dout SHALL be the candidate word at the latched offset, registered; latency is 1 cycle from the cycle W was formed.
REQ-018 io_comma SHALL be registered alongside io_dout.
REQ-019 SHALL have FSM states HUNT, VERIFY, LOCKED, and a 4-bit comma counter.
REQ-020 HUNT: a comma at any k SHALL latch offset=k, set count=1, and go to VERIFY, or go directly to LOCKED if LOCK_COMMAS=1.
REQ-021 VERIFY, comma at the latched offset: count SHALL increment; when count reaches LOCK_COMMAS the FSM SHALL go to LOCKED.
REQ-022 VERIFY, comma at a different offset only: offset SHALL relatch, count=1, and the FSM SHALL stay in VERIFY.
REQ-023 VERIFY, io_dec_error=1: the FSM SHALL go to HUNT and count SHALL clear, taking priority over REQ-021/REQ-022 in the same cycle.
REQ-024 Non-comma words in VERIFY SHALL leave state and count unchanged.
REQ-025 LOCKED: offset SHALL be frozen, and commas at other offsets SHALL be ignored.
REQ-026 LOCKED: a window counter SHALL increment each cycle; on wrap at ERR_WINDOW it SHALL clear the error counter.
REQ-027 LOCKED: io_dec_error=1 SHALL increment the error counter.
REQ-028 When the error counter reaches ERR_LIMIT, the FSM SHALL go to HUNT next cycle and both counters SHALL clear.
REQ-029 An error in the wrap cycle SHALL count into the new window, i.e. the counter SHALL be set to 1.
REQ-030 Error counter SHALL saturate at ERR_LIMIT; window counter SHALL wrap modulo ERR_WINDOW.
REQ-031 io_comma SHALL be 1 only in LOCKED or VERIFY and only for a comma at the latched offset; otherwise 0.
REQ-032 io_locked SHALL equal (state==LOCKED), registered, with no extra latency beyond the state register.
REQ-033 io_dec_error SHALL be ignored in HUNT.

Reset
REQ-034 While reset=1, on each clock edge: state=HUNT, offset=0, prev=0, all counters=0, io_dout=0, io_comma=0, io_locked=0, io_offset=0.
REQ-035 Reset asserted mid-VERIFY or mid-LOCKED SHALL abort immediately with no partial lock retained.
REQ-036 The first window after reset release SHALL use prev=0.

Verification
REQ-037 Aligned K28.5 0011111010 repeated from reset release -> offset 0; io_locked=1 after the 3rd comma; io_dout=0011111010 and io_comma=1 every cycle.
REQ-038 Same stream delayed by 3 bits (raw words built from the shifted bitstream) -> io_offset=3; lock after 3 commas; io_dout equals the unshifted group sequence 1 cycle late.
REQ-039 In VERIFY after 2 commas at offset 3, one comma at offset 6 -> offset relatches to 6, count=1; lock needs 2 more commas at offset 6 for a total of 3.
REQ-040 Locked, with io_dec_error pulsed 4 times within 256 cycles -> HUNT the cycle after the 4th, io_locked=0; 3 errors per window repeated over 1000 cycles -> stays locked.
REQ-041 Locked, alternating K28.5 RD- 0011111010 and RD+ 1100000101 with data words D21.5 1010101010 between -> both comma forms flagged; io_comma=0 on data words.
REQ-042 Reset pulsed for 1 cycle while LOCKED -> all outputs 0 the next cycle; relock requires 3 fresh commas.

Source files
------------

// File: rtl/link_rx_align.sv
// Comma-based word aligner for a 10-bit deserialized line: hunts for K28.x commas,
// verifies a stable bit offset, then holds lock until decode errors exceed a per-window budget.
module link_rx_align #(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter int unsigned ERR_WINDOW  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] io_din,
  input  logic       io_dec_error,
  output logic [9:0] io_dout,
  output logic       io_comma,
  output logic       io_locked,
  output logic [3:0] io_offset
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int unsigned WW     = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [7:0]  ERR_N  = 8'(ERR_LIMIT);

  logic [1:0]    state, state_nx;
  logic [3:0]    offset, offset_nx;
  logic [3:0]    count, count_nx;
  logic [7:0]    errcnt, errcnt_nx, err_base;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [9:0]    prev;
  logic [19:0]   win;
  logic [9:0]    cand [16];
  logic [15:0]   comma_vec;
  logic          comma_any;
  logic [3:0]    comma_k;

  assign win = {prev, io_din};

  // Offsets 10..15 are padding so a 4-bit offset can index the tables directly.
  for (genvar g = 0; g < 16; g++) begin : g_cand
    if (g < 10) begin : g_live
      assign cand[g]      = win[19-g -: 10];
      assign comma_vec[g] = (win[19-g -: 7] == 7'b0011111) ||
                            (win[19-g -: 7] == 7'b1100000);
    end else begin : g_pad
      assign cand[g]      = '0;
      assign comma_vec[g] = 1'b0;
    end
  end

  // Lowest offset wins when several commas appear in one window.
  always_comb begin
    comma_any = 1'b0;
    comma_k   = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (comma_vec[i] && !comma_any) begin
        comma_any = 1'b1;
        comma_k   = 4'(i);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    offset_nx = offset;
    count_nx  = count;
    errcnt_nx = errcnt;
    wcnt_nx   = wcnt;
    err_base  = '0;
    case (state)
      HUNT: begin
        if (comma_any) begin
          offset_nx = comma_k;
          count_nx  = 4'd1;
          state_nx  = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (io_dec_error) begin
          state_nx = HUNT;
          count_nx = '0;
        end else if (comma_vec[offset]) begin
          count_nx = count + 4'd1;
          if (count_nx == LOCK_N) state_nx = LOCKED;
        end else if (comma_any) begin
          offset_nx = comma_k;
          count_nx  = 4'd1;
        end
      end
      LOCKED: begin
        wcnt_nx = wcnt + WW'(1);
        // The wrap cycle starts a fresh window, so an error seen there counts into it.
        err_base = (&wcnt) ? '0 : errcnt;
        if (io_dec_error)
          errcnt_nx = (err_base == ERR_N) ? err_base : err_base + 8'd1;
        else
          errcnt_nx = err_base;
        if (errcnt_nx == ERR_N) begin
          state_nx  = HUNT;
          count_nx  = '0;
          wcnt_nx   = '0;
          errcnt_nx = '0;
        end
      end
      default: begin
        state_nx  = HUNT;
        count_nx  = '0;
        wcnt_nx   = '0;
        errcnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      offset   <= '0;
      count    <= '0;
      errcnt   <= '0;
      wcnt     <= '0;
      prev     <= '0;
      io_dout  <= '0;
      io_comma <= 1'b0;
    end else begin
      state    <= state_nx;
      offset   <= offset_nx;
      count    <= count_nx;
      errcnt   <= errcnt_nx;
      wcnt     <= wcnt_nx;
      prev     <= io_din;
      io_dout  <= cand[offset];
      io_comma <= ((state == VERIFY) || (state == LOCKED)) && comma_vec[offset];
    end
  end

  assign io_locked = (state == LOCKED);
  assign io_offset = offset;

endmodule

// File: tb/tb_link_rx_align.sv
// Directed bench for link_rx_align: hunt/verify/lock sequencing, offset relatch,
// error-window unlock, comma flagging and reset abort.
module tb_link_rx_align;

  localparam logic [9:0] K_M = 10'b0011111010;
  localparam logic [9:0] K_P = 10'b1100000101;
  localparam logic [9:0] D21 = 10'b1010101010;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] din;
  logic       dec_err;
  logic [9:0] dout;
  logic       comma;
  logic       locked;
  logic [3:0] offset;

  int checks   = 0;
  int failures = 0;

  link_rx_align #(
    .LOCK_COMMAS(3),
    .ERR_LIMIT  (4),
    .ERR_WINDOW (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_din      (din),
    .io_dec_error(dec_err),
    .io_dout     (dout),
    .io_comma    (comma),
    .io_locked   (locked),
    .io_offset   (offset)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [9:0] d, input logic e);
    din     = d;
    dec_err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(10'h3FF, 1'b1);
    step(10'h3FF, 1'b0);
    reset = 1'b0;
  endtask

  task automatic lock_aligned();
    do_reset();
    repeat (4) step(K_M, 1'b0);
  endtask

  function automatic logic [9:0] shifted(input logic [9:0] gp, input logic [9:0] gc,
                                         input int unsigned s);
    logic [19:0] t;
    t = {gp, gc} >> s;
    return t[9:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(10'h2AA, 1'b1);
    step(10'h155, 1'b0);
    checks++;
    if ({dout, comma, locked, offset} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got %h want %h", {dout, comma, locked, offset}, 16'h0000);
    end
    reset = 1'b0;
  endtask

  task automatic test_aligned();
    logic [15:0] exp_v [4];
    exp_v[0] = {10'b0, 1'b0, 1'b0, 4'd0};
    exp_v[1] = {K_M,   1'b0, 1'b0, 4'd0};
    exp_v[2] = {K_M,   1'b1, 1'b0, 4'd0};
    exp_v[3] = {K_M,   1'b1, 1'b1, 4'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(K_M, (i == 1));   // error during HUNT must be ignored
      checks++;
      if ({dout, comma, locked, offset} !== exp_v[i]) begin
        failures++;
        $display("FAIL aligned_step%0d: got %h want %h", i, {dout, comma, locked, offset}, exp_v[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(K_M, 1'b0);
      checks++;
      if ({dout, comma, locked, offset} !== {K_M, 1'b1, 1'b1, 4'd0}) begin
        failures++;
        $display("FAIL aligned_steady%0d: got %h want %h", i, {dout, comma, locked, offset},
                 {K_M, 1'b1, 1'b1, 4'd0});
      end
    end
  endtask

  task automatic test_verify_error();
    logic [15:0] exp_v [5];
    exp_v[0] = {K_M, 1'b0, 1'b0, 4'd0};
    exp_v[1] = {K_M, 1'b1, 1'b0, 4'd0};
    exp_v[2] = {K_M, 1'b0, 1'b0, 4'd0};
    exp_v[3] = {K_M, 1'b1, 1'b0, 4'd0};
    exp_v[4] = {K_M, 1'b1, 1'b1, 4'd0};
    do_reset();
    step(K_M, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(K_M, (i == 1));
      checks++;
      if ({dout, comma, locked, offset} !== exp_v[i]) begin
        failures++;
        $display("FAIL verify_error_step%0d: got %h want %h", i, {dout, comma, locked, offset}, exp_v[i]);
      end
    end
  endtask

  task automatic test_shift3();
    logic [9:0] g [10];
    logic [9:0] gp;
    logic       is_k;
    g = '{K_M, K_M, K_M, K_M, K_M, D21, K_M, D21, K_P, D21};
    do_reset();
    gp = '0;
    for (int i = 0; i < 10; i++) begin
      step(shifted(gp, g[i], 3), 1'b0);
      gp = g[i];
      checks++;
      if (offset !== ((i >= 1) ? 4'd3 : 4'd0)) begin
        failures++;
        $display("FAIL shift3_offset%0d: got %0d want %0d", i, offset, (i >= 1) ? 3 : 0);
      end
      checks++;
      if (locked !== (i >= 3)) begin
        failures++;
        $display("FAIL shift3_locked%0d: got %b want %b", i, locked, (i >= 3));
      end
      if (i >= 2) begin
        is_k = (g[i-1] == K_M) || (g[i-1] == K_P);
        checks++;
        if ({dout, comma} !== {g[i-1], is_k}) begin
          failures++;
          $display("FAIL shift3_data%0d: got %h want %h", i, {dout, comma}, {g[i-1], is_k});
        end
      end
    end
  endtask

  task automatic test_relatch();
    logic [9:0] r [6];
    logic [5:0] exp_v [6];
    r = '{10'b0000011111, 10'b0100011111, 10'b0100000011,
          10'b1110100011, 10'b1110100011, 10'b1110100011};
    exp_v = '{{1'b0, 1'b0, 4'd0}, {1'b0, 1'b0, 4'd3}, {1'b1, 1'b0, 4'd3},
              {1'b0, 1'b0, 4'd6}, {1'b1, 1'b0, 4'd6}, {1'b1, 1'b1, 4'd6}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(r[i], 1'b0);
      checks++;
      if ({comma, locked, offset} !== exp_v[i]) begin
        failures++;
        $display("FAIL relatch_step%0d: got %h want %h", i, {comma, locked, offset}, exp_v[i]);
      end
      if (i >= 4) begin
        checks++;
        if (dout !== K_M) begin
          failures++;
          $display("FAIL relatch_dout%0d: got %b want %b", i, dout, K_M);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] r [5];
    r = '{10'b0000011111, 10'b0100011111, 10'b0100000011, 10'b1110100011, 10'b1110100011};
    do_reset();
    for (int i = 0; i < 5; i++) step(r[i], 1'b0);
    reset = 1'b1;
    step(10'b1110100011, 1'b0);
    reset = 1'b0;
    checks++;
    if ({dout, comma, locked, offset} !== 16'h0000) begin
      failures++;
      $display("FAIL abort_verify: got %h want %h", {dout, comma, locked, offset}, 16'h0000);
    end
    for (int i = 0; i < 4; i++) begin
      step(K_M, 1'b0);
      checks++;
      if (locked !== (i == 3)) begin
        failures++;
        $display("FAIL abort_verify_relock%0d: got %b want %b", i, locked, (i == 3));
      end
    end
    lock_aligned();
    reset = 1'b1;
    step(K_M, 1'b0);
    reset = 1'b0;
    checks++;
    if ({dout, comma, locked, offset} !== 16'h0000) begin
      failures++;
      $display("FAIL abort_locked: got %h want %h", {dout, comma, locked, offset}, 16'h0000);
    end
    for (int i = 0; i < 4; i++) begin
      step(K_M, 1'b0);
      checks++;
      if (locked !== (i == 3)) begin
        failures++;
        $display("FAIL abort_locked_relock%0d: got %b want %b", i, locked, (i == 3));
      end
    end
  endtask

  task automatic test_err_limit();
    lock_aligned();
    for (int p = 0; p < 42; p++) begin
      step(K_M, (p == 10) || (p == 20) || (p == 30) || (p == 40));
      checks++;
      if (locked !== (p < 40)) begin
        failures++;
        $display("FAIL err_limit_p%0d: got %b want %b", p, locked, (p < 40));
      end
    end
  endtask

  task automatic test_err_budget();
    int m;
    lock_aligned();
    for (int p = 0; p < 1000; p++) begin
      m = p % 256;
      step(K_M, (m == 50) || (m == 100) || (m == 150));
      checks++;
      if (locked !== 1'b1) begin
        failures++;
        $display("FAIL err_budget_p%0d: got %b want 1", p, locked);
      end
    end
  endtask

  task automatic test_err_wrap();
    lock_aligned();
    for (int p = 0; p < 260; p++) begin
      step(K_M, (p >= 253) && (p <= 258));
      checks++;
      if (locked !== (p < 258)) begin
        failures++;
        $display("FAIL err_wrap_p%0d: got %b want %b", p, locked, (p < 258));
      end
    end
  endtask

  task automatic test_comma_forms();
    logic [9:0] seq [8];
    logic [9:0] exp_d;
    logic       exp_c;
    seq = '{K_M, D21, K_P, D21, K_M, D21, K_P, D21};
    lock_aligned();
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b0);
      exp_d = (i == 0) ? K_M : seq[i-1];
      exp_c = (exp_d == K_M) || (exp_d == K_P);
      checks++;
      if ({dout, comma, locked} !== {exp_d, exp_c, 1'b1}) begin
        failures++;
        $display("FAIL comma_forms%0d: got %h want %h", i, {dout, comma, locked}, {exp_d, exp_c, 1'b1});
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    din     = '0;
    dec_err = 1'b0;
    test_reset();
    test_aligned();
    test_verify_error();
    test_shift3();
    test_relatch();
    test_reset_abort();
    test_err_limit();
    test_err_budget();
    test_err_wrap();
    test_comma_forms();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
